gecko_load_align: RTL and testbench

GECKO_LOAD_ALIGN -- requirements
Module: gecko_load_align

---
 rtl/gecko_load_align.sv | 154 +++++++++++++++
 tb/tb_gecko_load_align.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/gecko_load_align.sv
// gecko_load_align: in-order load command queue that pairs memory data with commands and aligns it.
// Optional same-cycle queue bypass under GECKO_LOAD_ALIGN_BYPASS_EN.
package gecko_load_align_pkg;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  typedef struct packed {
    logic [4:0] addr;
    logic [2:0] reg_status;
    logic       jump_flag;
    logic [2:0] op;
    logic [1:0] offset;
  } gecko_mem_operation_t;

  typedef struct packed {
    logic [31:0] value;
    logic [4:0]  addr;
    logic [2:0]  reg_status;
    logic        jump_flag;
    logic        speculative;
  } gecko_operation_t;

  function automatic gecko_operation_t gecko_get_load_operation(
    input gecko_mem_operation_t c,
    input logic [31:0]          d
  );
    gecko_operation_t r;
    logic [31:0]      s;
    s = d >> {c.offset, 3'b000};
    r = '0;
    r.addr        = c.addr;
    r.reg_status  = c.reg_status;
    r.jump_flag   = c.jump_flag;
    r.speculative = 1'b0;
    case (c.op)
      LS_B:    r.value = {{24{s[7]}}, s[7:0]};
      LS_H:    r.value = {{16{s[15]}}, s[15:0]};
      LS_BU:   r.value = {24'h0, s[7:0]};
      LS_HU:   r.value = {16'h0, s[15:0]};
      default: r.value = d;
    endcase
    return r;
  endfunction

endpackage

module gecko_load_align
  import gecko_load_align_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [13:0]              cmd,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [31:0]              mem_data,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [41:0]              wb_op,
  output logic [$clog2(DEPTH):0]   pending,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  gecko_mem_operation_t q_mem [DEPTH];
  gecko_mem_operation_t cmd_in;
  gecko_mem_operation_t src;

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          rdy_en;
  logic          out_v;
  logic          uflow;
  gecko_operation_t out_q;

  logic empty;
  logic full;
  logic out_free;
  logic cmd_fire;
  logic mem_fire;
  logic byp;
  logic push;
  logic pop;

  assign cmd_in   = gecko_mem_operation_t'(cmd);
  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign out_free = !out_v || wb_ready;
  assign cmd_ready = rdy_en && !full;
  assign cmd_fire = cmd_valid && cmd_ready;

`ifdef GECKO_LOAD_ALIGN_BYPASS_EN
  // An empty queue may still take data if the command arrives alongside it.
  assign mem_ready = (!empty || cmd_fire) && out_free;
  assign byp       = empty && cmd_fire && mem_valid && out_free;
`else
  assign mem_ready = !empty && out_free;
  assign byp       = 1'b0;
`endif

  assign mem_fire = mem_valid && mem_ready;
  assign pop      = mem_fire && !byp;
  assign push     = cmd_fire && !byp;
  assign src      = byp ? cmd_in : q_mem[rd_ptr];

  assign wb_valid  = out_v;
  assign wb_op     = out_q;
  assign pending   = count;
  assign underflow = uflow;

  always_ff @(posedge clk) begin
    if (push) q_mem[wr_ptr] <= cmd_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      rdy_en <= 1'b0;
      out_v  <= 1'b0;
      out_q  <= '0;
      uflow  <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (mem_fire) begin
        out_v <= 1'b1;
        out_q <= gecko_get_load_operation(src, mem_data);
      end else if (out_v && wb_ready) begin
        out_v <= 1'b0;
        out_q <= '0;
      end
      if (mem_valid && empty && !byp) uflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gecko_load_align.sv
// tb_gecko_load_align: random and directed traffic checked against a queue-based reference model.
// Bypass expectations follow GECKO_LOAD_ALIGN_BYPASS_EN when defined.
module tb_gecko_load_align;
  import gecko_load_align_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [13:0] cmd;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_data;
  logic        wb_valid;
  logic        wb_ready;
  logic [41:0] wb_op;
  logic [$clog2(DEPTH):0] pending;
  logic        underflow;

  int total = 0;
  int bad   = 0;

  gecko_mem_operation_t m_q[$];
  logic        m_out_v;
  logic [41:0] m_out;
  logic        m_uf;
  logic        m_en;

  logic [2:0] ops [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  gecko_load_align #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_data(mem_data),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_op(wb_op),
    .pending(pending), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [41:0] ref_load(input logic [13:0] c,
                                           input logic [31:0] d);
    logic [31:0] b, h, v;
    logic [1:0]  off;
    off = c[1:0];
    b = (d >> (8 * off)) % 256;
    h = (d >> (8 * off)) % 65536;
    case (c[4:2])
      3'b000:  v = (b < 128) ? b : b + 32'hFFFF_FF00;
      3'b001:  v = (h < 32768) ? h : h + 32'hFFFF_0000;
      3'b100:  v = b;
      3'b101:  v = h;
      default: v = d;
    endcase
    return {v, c[13:9], c[8:6], c[5], 1'b0};
  endfunction

  task automatic step(input logic cv, input logic [13:0] c,
                      input logic mv, input logic [31:0] d,
                      input logic wr);
    logic e_cr, e_mr, ofree, cf, mf, byp;
    int   sz;
    @(negedge clk);
    cmd_valid = cv; cmd = c; mem_valid = mv; mem_data = d; wb_ready = wr;
    #1;
    sz    = m_q.size();
    e_cr  = m_en && (sz < DEPTH);
    ofree = !m_out_v || wr;
`ifdef GECKO_LOAD_ALIGN_BYPASS_EN
    e_mr  = (sz > 0 || (cv && e_cr)) && ofree;
`else
    e_mr  = (sz > 0) && ofree;
`endif
    chk("cmd_ready", 64'(cmd_ready), 64'(e_cr));
    chk("mem_ready", 64'(mem_ready), 64'(e_mr));
    chk("wb_valid",  64'(wb_valid),  64'(m_out_v));
    chk("wb_op",     64'(wb_op),     64'(m_out));
    chk("pending",   64'(pending),   64'(sz));
    chk("underflow", 64'(underflow), 64'(m_uf));
    cf  = cv && e_cr;
    mf  = mv && e_mr;
    byp = mf && (sz == 0);
    if (mf) begin
      if (byp) m_out = ref_load(c, d);
      else     m_out = ref_load(m_q.pop_front(), d);
      m_out_v = 1'b1;
    end else if (m_out_v && wr) begin
      m_out_v = 1'b0;
      m_out   = '0;
    end
    if (cf && !byp) m_q.push_back(gecko_mem_operation_t'(c));
    if (mv && sz == 0 && !byp) m_uf = 1'b1;
    m_en = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cmd_valid = 1'b0; mem_valid = 1'b0; wb_ready = 1'b0;
    cmd = '0; mem_data = '0;
    #1;
    chk("rst_wb_valid",  64'(wb_valid),  64'(0));
    chk("rst_wb_op",     64'(wb_op),     64'(0));
    chk("rst_pending",   64'(pending),   64'(0));
    chk("rst_underflow", 64'(underflow), 64'(0));
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    chk("rst_mem_ready", 64'(mem_ready), 64'(0));
    m_q.delete();
    m_out_v = 1'b0; m_out = '0; m_uf = 1'b0; m_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rel_cmd_ready", 64'(cmd_ready), 64'(0));
    m_en = 1'b1;
  endtask

  function automatic logic [13:0] mk(input logic [4:0] a, input logic [2:0] op,
                                     input logic [1:0] off);
    return {a, 3'd1, 1'b0, op, off};
  endfunction

  function automatic logic [13:0] rnd_cmd();
    logic [13:0] c;
    c = 14'($urandom);
    c[4:2] = ops[$urandom % 5];
    return c;
  endfunction

  initial begin
    do_reset();

    step(1, mk(5'd5, 3'b000, 2'd2), 0, 0, 1);
    step(0, 0, 1, 32'h1280_3456, 1);
    step(0, 0, 0, 0, 1);
    chk("lb_value", 64'(wb_op[41:10]), 64'h0000_0000_FFFF_FF80);
    chk("lb_addr",  64'(wb_op[9:5]),   64'd5);
    chk("lb_spec",  64'(wb_op[0]),     64'd0);

    step(1, mk(5'd7, 3'b101, 2'd2), 0, 0, 1);
    step(1, mk(5'd8, 3'b001, 2'd2), 1, 32'hBEEF_0001, 1);
    step(0, 0, 1, 32'hBEEF_0001, 1);
    chk("lhu_value", 64'(wb_op[41:10]), 64'h0000_BEEF);
    step(0, 0, 0, 0, 1);
    chk("lh_value", 64'(wb_op[41:10]), 64'hFFFF_BEEF);
    step(0, 0, 0, 0, 1);

    for (int i = 0; i < 4; i++) step(1, rnd_cmd(), 0, 0, 1);
    step(1, rnd_cmd(), 1, $urandom, 1);
    step(0, 0, 0, 0, 1);
    while (m_q.size() > 0) step(0, 0, 1, $urandom, 1);
    step(0, 0, 0, 0, 1);

    step(1, rnd_cmd(), 0, 0, 0);
    step(1, rnd_cmd(), 1, $urandom, 0);
    step(0, 0, 1, $urandom, 0);
    step(0, 0, 1, $urandom, 0);
    step(0, 0, 1, $urandom, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    for (int i = 0; i < 600; i++) begin
      logic mv;
      mv = (m_q.size() > 0) && ($urandom % 3 != 0);
      step(($urandom % 2) == 1, rnd_cmd(), mv, $urandom,
           (i % 100 < 30) ? ($urandom % 5 == 0) : ($urandom % 4 != 0));
    end
    while (m_q.size() > 0) step(0, 0, 1, $urandom, 1);
    step(0, 0, 0, 0, 1);

    step(0, 0, 1, $urandom, 1);
    step(0, 0, 0, 0, 1);
    chk("uf_flag", 64'(underflow), 64'(1));
    chk("uf_no_wb", 64'(wb_valid), 64'(0));
    @(posedge clk); #3;
    do_reset();

`ifdef GECKO_LOAD_ALIGN_BYPASS_EN
    step(1, mk(5'd9, 3'b100, 2'd3), 1, 32'hA500_0000, 1);
    step(0, 0, 0, 0, 1);
    chk("byp_value", 64'(wb_op[41:10]), 64'h0000_00A5);
    chk("byp_uf",    64'(underflow),    64'(0));
    step(0, 0, 0, 0, 1);
`endif

    for (int i = 0; i < 4; i++) step(1, rnd_cmd(), 0, 0, 0);
    step(0, 0, 1, $urandom, 0);
    step(0, 0, 0, 0, 0);
    chk("pre_rst_pending", 64'(pending), 64'(3));
    chk("pre_rst_wb_valid", 64'(wb_valid), 64'(1));
    @(posedge clk); #3;
    do_reset();

    step(1, mk(5'd3, 3'b010, 2'd0), 0, 0, 1);
    step(0, 0, 1, 32'hCAFE_F00D, 1);
    step(0, 0, 0, 0, 1);
    chk("post_rst_value", 64'(wb_op[41:10]), 64'hCAFE_F00D);
    step(0, 0, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
